alu_pipeline: RTL and testbench
===============================

# alu_pipeline

Parametrised successor to the fixed three-stage pipeline. It is an N-stage ALU pipeline with a valid/ready handshake on both ends, per-stage bubble collapsing, synchronous flush and an occupancy counter. It sits between the operand source and result sink in the pd datapath, and it is instantiated once per lane from the pd top level.

## Interface
Parameters:
- DWIDTH, 32, operand/result width in bits (≥ 2)
- STAGES, 3, number of register stages; legal range 2–16

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- valid_i  input  1  upstream presents an operation
- ready_o  output  1  pipeline accepts the operation this cycle
- op1_i  input  DWIDTH  operand 1
- op2_i  input  DWIDTH  operand 2
- sel_i  input  2  operation select (alu_op_e)
- flush_i  input  1  discard all in-flight operations
- valid_o  output  1  result available at tail
- ready_i  input  1  downstream accepts the result
- res_o  output  DWIDTH  result
- zero_o  output  1  res_o == 0
- neg_o  output  1  res_o[DWIDTH-1]
- count_o  output  $clog2(STAGES+1)  number of occupied stages

## Operation
- Ops: ADD=2'b00 op1+op2; SUB=2'b01 op1−op2; AND=2'b10; OR=2'b11.
- ADD and SUB wrap modulo 2^DWIDTH. There is no carry-out or overflow output.
- The ALU result and flags are computed combinationally at entry and captured into stage 0 on acceptance.
- Stages 1..STAGES−1 carry {valid, res, zero, neg} unchanged.
- Transfer in: valid_i && ready_o. Transfer out: valid_o && ready_i.
- Stage k advances when it is empty or stage k+1 advances. The tail stage advances when ready_i is high.
- ready_o = !flush_i && (stage 0 empty || stage 0 advances).
- The ready chain is combinational from ready_i to ready_o. Bubbles collapse: an empty stage always accepts.
- A stage whose upstream moves no data becomes empty (valid=0). Data registers of empty stages hold their value; they are don't-care.
- valid_o, res_o, zero_o and neg_o are driven directly from the tail stage registers.
- While valid_o=1 and ready_i=0, the tail payload stays stable.
- flush_i=1: all stage valid bits clear at the next edge. count_o becomes 0. Any valid_i that cycle is not accepted, because ready_o=0.
- A tail result presented during a flush cycle counts as transferred only if ready_i=1 in that cycle.
- count_o tracks the number of valid stages:
  - increments on transfer in
  - decrements on transfer out
  - unchanged when both occur in one cycle
  - forced to 0 by flush or rst
- rst has priority over flush_i, and flush_i has priority over the handshakes.

## Timing
- Reset values: all stage valid bits, valid_o, res_o, zero_o, neg_o and count_o = 0. ready_o = 1 in the cycle after rst deasserts, unless flush_i is high.
- Latency: an op accepted at edge t appears on valid_o after edge t+STAGES−1, i.e. STAGES cycles after valid_i is sampled, when no stall occurs.
- Throughput: 1 op/cycle with ready_i held high.
- Full: count_o == STAGES with ready_i=0 gives ready_o=0. Raising ready_i then makes ready_o=1 in the same cycle.
- rst mid-operation: all in-flight ops are lost and none appears on the output.

## Structure
- Package alu_pipeline_pkg holds:
  - typedef enum logic [1:0] alu_op_e {ADD, SUB, AND, OR}
  - localparams MIN_STAGES=2 and MAX_STAGES=16
  - function alu_compute(op1, op2, sel), returning result and flags
- Sub-module pipe_slot: one stage register with valid, payload and advance logic, parametrised on payload width.
- Stages are built with a generate loop of pipe_slot instances.
- An elaboration-time assertion checks that STAGES is within MIN_STAGES..MAX_STAGES.

## Test plan
- Reset, then stream with STAGES=3, DWIDTH=32, ready_i=1:
  - ADD 5+7, SUB 3−5, AND F0F0&0FF0, OR 0+0 on 4 consecutive cycles
  - required: results 12, FFFFFFFE (neg_o=1), 000000F0, 0 (zero_o=1) on 4 consecutive cycles, with the first 3 cycles after first acceptance
- Overflow: ADD FFFFFFFF+1 → res_o=0, zero_o=1.
- Backpressure: ready_i=0, feed 5 ops.
  - Required: exactly 3 accepted, count_o=3, ready_o=0, tail payload stable.
  - Then ready_i=1: the 3 results drain in order, one per cycle.
- Bubble collapse: valid_i pattern 1,0,0,1 with ready_i=0.
  - Required: both ops packed into the tail two stages, count_o=2, ready_o=1.
- Flush with 2 in flight and valid_i=1: ready_o=0 that cycle, count_o=0 and valid_o=0 next cycle, and the flushed ops never emerge.
- rst asserted mid-stream with STAGES=16: all outputs 0 on the next cycle, and the first post-reset op emerges with 16-cycle latency.

Source files
------------

// File: rtl/alu_pipeline_pkg.sv
// Shared operation encoding, stage limits and the entry-stage ALU function
// used by alu_pipeline.
package alu_pipeline_pkg;

   localparam int unsigned MIN_STAGES = 2;
   localparam int unsigned MAX_STAGES = 16;
   localparam int unsigned MAX_DWIDTH = 64;

   typedef enum logic [1:0] {
      ADD = 2'b00,
      SUB = 2'b01,
      AND = 2'b10,
      OR  = 2'b11
   } alu_op_e;

   typedef struct packed {
      logic [MAX_DWIDTH-1:0] res;
      logic                  zero;
      logic                  neg;
   } alu_res_t;

   // Operands arrive zero-extended to MAX_DWIDTH; dwidth selects the live slice
   // so the wrap, zero and sign flags all follow the instance width.
   function automatic alu_res_t alu_compute(input logic [MAX_DWIDTH-1:0] op1,
                                            input logic [MAX_DWIDTH-1:0] op2,
                                            input alu_op_e               sel,
                                            input int unsigned           dwidth);
      alu_res_t              out;
      logic [MAX_DWIDTH-1:0] one;
      logic [MAX_DWIDTH-1:0] mask;
      one      = MAX_DWIDTH'(1);
      mask     = (one << dwidth) - one;
      out.res  = '0;
      case (sel)
         ADD:     out.res = op1 + op2;
         SUB:     out.res = op1 - op2;
         AND:     out.res = op1 & op2;
         default: out.res = op1 | op2;
      endcase
      out.res  = out.res & mask;
      out.zero = (out.res == '0);
      out.neg  = |(out.res & (one << (dwidth - 1)));
      return out;
   endfunction

endpackage

// File: rtl/alu_pipeline_slot.sv
// One pipeline register: valid bit plus payload, advancing whenever it is
// empty or its downstream neighbour advances.
module pipe_slot #(
   parameter int unsigned PWIDTH = 34
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              up_valid_i,
   input  logic [PWIDTH-1:0] up_data_i,
   input  logic              down_adv_i,
   output logic              adv_o,
   output logic              valid_o,
   output logic [PWIDTH-1:0] data_o
);

   logic              r_valid;
   logic [PWIDTH-1:0] r_data;

   assign adv_o = !r_valid || down_adv_i;

   // Payload of an empty slot is left alone; only the valid bit tracks bubbles.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (flush_i) begin
         r_valid <= 1'b0;
      end else if (adv_o) begin
         r_valid <= up_valid_i;
         if (up_valid_i) begin
            r_data <= up_data_i;
         end
      end
   end

   assign valid_o = r_valid;
   assign data_o  = r_data;

endmodule

// File: rtl/alu_pipeline.sv
// N-stage ALU pipeline with valid/ready on both ends, bubble collapsing,
// synchronous flush and an occupancy counter.
module alu_pipeline
   import alu_pipeline_pkg::*;
#(
   parameter int unsigned DWIDTH = 32,
   parameter int unsigned STAGES = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        valid_i,
   output logic                        ready_o,
   input  logic [DWIDTH-1:0]           op1_i,
   input  logic [DWIDTH-1:0]           op2_i,
   input  logic [1:0]                  sel_i,
   input  logic                        flush_i,
   output logic                        valid_o,
   input  logic                        ready_i,
   output logic [DWIDTH-1:0]           res_o,
   output logic                        zero_o,
   output logic                        neg_o,
   output logic [$clog2(STAGES+1)-1:0] count_o
);

   localparam int unsigned CW = $clog2(STAGES + 1);
   localparam int unsigned PW = DWIDTH + 2;

   if (STAGES < MIN_STAGES || STAGES > MAX_STAGES) begin : g_bad_stages
      $error("alu_pipeline: STAGES must lie within MIN_STAGES..MAX_STAGES");
   end
   if (DWIDTH < 2 || DWIDTH > MAX_DWIDTH) begin : g_bad_dwidth
      $error("alu_pipeline: DWIDTH must lie within 2..MAX_DWIDTH");
   end

   logic [MAX_DWIDTH-1:0] w_op1_ext;
   logic [MAX_DWIDTH-1:0] w_op2_ext;
   alu_res_t              w_alu;
   logic [PW-1:0]         w_entry;
   logic                  w_xfer_in;
   logic                  w_xfer_out;
   logic [CW-1:0]         r_count;
   logic [CW-1:0]         w_count_d;

   always_comb begin
      w_op1_ext               = '0;
      w_op2_ext               = '0;
      w_op1_ext[DWIDTH-1:0]   = op1_i;
      w_op2_ext[DWIDTH-1:0]   = op2_i;
      w_alu                   = alu_compute(w_op1_ext, w_op2_ext, alu_op_e'(sel_i), DWIDTH);
      w_entry                 = {w_alu.res[DWIDTH-1:0], w_alu.zero, w_alu.neg};
   end

   // Advance enables are kept per generate scope so the ready chain from the
   // tail back to the head is a plain combinational path, not a self-loop.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic          w_in_valid;
      logic [PW-1:0] w_in_data;
      logic          w_nxt_adv;
      logic          w_adv;
      logic          w_valid;
      logic [PW-1:0] w_data;

      if (k == 0) begin : g_head
         assign w_in_valid = w_xfer_in;
         assign w_in_data  = w_entry;
      end else begin : g_body
         assign w_in_valid = g_stage[k-1].w_valid;
         assign w_in_data  = g_stage[k-1].w_data;
      end

      if (k == STAGES - 1) begin : g_tail
         assign w_nxt_adv = ready_i;
      end else begin : g_mid
         assign w_nxt_adv = g_stage[k+1].w_adv;
      end

      pipe_slot #(
         .PWIDTH(PW)
      ) u_slot (
         .clk        (clk),
         .rst        (rst),
         .flush_i    (flush_i),
         .up_valid_i (w_in_valid),
         .up_data_i  (w_in_data),
         .down_adv_i (w_nxt_adv),
         .adv_o      (w_adv),
         .valid_o    (w_valid),
         .data_o     (w_data)
      );
   end

   assign ready_o    = !flush_i && g_stage[0].w_adv;
   assign w_xfer_in  = valid_i && ready_o;
   assign w_xfer_out = valid_o && ready_i;

   assign valid_o                 = g_stage[STAGES-1].w_valid;
   assign {res_o, zero_o, neg_o}  = g_stage[STAGES-1].w_data;

   always_comb begin
      w_count_d = r_count;
      if (flush_i) begin
         w_count_d = '0;
      end else begin
         case ({w_xfer_in, w_xfer_out})
            2'b10:   w_count_d = r_count + 1'b1;
            2'b01:   w_count_d = r_count - 1'b1;
            default: w_count_d = r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_d;
      end
   end

   assign count_o = r_count;

endmodule

// File: tb/tb_alu_pipeline.sv
// Self-checking bench for alu_pipeline: directed table, hand-written
// backpressure/bubble/flush/reset sequences and a randomized queue model.
module tb_alu_pipeline;
   import alu_pipeline_pkg::*;

   localparam int unsigned W  = 32;
   localparam int unsigned SA = 3;
   localparam int unsigned SB = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          a_rst, a_valid_i, a_ready_o, a_flush, a_valid_o, a_ready_i, a_zero, a_neg;
   logic [W-1:0]  a_op1, a_op2, a_res;
   logic [1:0]    a_sel;
   logic [1:0]    a_count;
   logic          b_rst, b_valid_i, b_ready_o, b_flush, b_valid_o, b_ready_i, b_zero, b_neg;
   logic [W-1:0]  b_op1, b_op2, b_res;
   logic [1:0]    b_sel;
   logic [4:0]    b_count;

   alu_pipeline #(.DWIDTH(W), .STAGES(SA)) dut_a (
      .clk(clk), .rst(a_rst), .valid_i(a_valid_i), .ready_o(a_ready_o), .op1_i(a_op1),
      .op2_i(a_op2), .sel_i(a_sel), .flush_i(a_flush), .valid_o(a_valid_o),
      .ready_i(a_ready_i), .res_o(a_res), .zero_o(a_zero), .neg_o(a_neg), .count_o(a_count)
   );

   alu_pipeline #(.DWIDTH(W), .STAGES(SB)) dut_b (
      .clk(clk), .rst(b_rst), .valid_i(b_valid_i), .ready_o(b_ready_o), .op1_i(b_op1),
      .op2_i(b_op2), .sel_i(b_sel), .flush_i(b_flush), .valid_o(b_valid_o),
      .ready_i(b_ready_i), .res_o(b_res), .zero_o(b_zero), .neg_o(b_neg), .count_o(b_count)
   );

   typedef struct {
      logic [1:0]   sel;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         zero;
      logic         neg;
   } vec_t;

   typedef struct {
      logic [W-1:0] res;
      logic         zero;
      logic         neg;
      int           t;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   vec_t vt[8];
   exp_t q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic exp_t ref_alu(input logic [1:0] sel, input logic [W-1:0] a,
                                    input logic [W-1:0] b);
      exp_t e;
      case (sel)
         2'd0:    e.res = a + b;
         2'd1:    e.res = a - b;
         2'd2:    e.res = a & b;
         default: e.res = a | b;
      endcase
      e.zero = (e.res == 0);
      e.neg  = e.res[W-1];
      e.t    = 0;
      return e;
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 3))
         0:       return '0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic drive_a(input logic v, input logic [1:0] s, input logic [W-1:0] x,
                          input logic [W-1:0] y);
      a_valid_i = v;
      a_sel     = s;
      a_op1     = x;
      a_op2     = y;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int acc;
      int seen;
      int found;
      logic exp_rdy;
      logic xin;
      logic xout;
      exp_t e;

      vt[0] = '{ADD, 32'd5,         32'd7,         32'd12,        1'b0, 1'b0};
      vt[1] = '{SUB, 32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0, 1'b1};
      vt[2] = '{AND, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 1'b0};
      vt[3] = '{OR,  32'd0,         32'd0,         32'd0,         1'b1, 1'b0};
      vt[4] = '{ADD, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1'b0};
      vt[5] = '{SUB, 32'h0000_1234, 32'h0000_1234, 32'd0,         1'b1, 1'b0};
      vt[6] = '{OR,  32'h8000_0000, 32'd1,         32'h8000_0001, 1'b0, 1'b1};
      vt[7] = '{AND, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0};

      a_rst = 1'b1; a_flush = 1'b0; a_ready_i = 1'b1; drive_a(1'b0, 2'd0, '0, '0);
      b_rst = 1'b1; b_flush = 1'b0; b_ready_i = 1'b1; b_valid_i = 1'b0;
      b_sel = 2'd0; b_op1 = '0; b_op2 = '0;
      repeat (3) next_cycle();
      a_rst = 1'b0;
      b_rst = 1'b0;
      #1;
      check("rst_valid_o", 64'(a_valid_o), 64'd0);
      check("rst_res_o",   64'(a_res),     64'd0);
      check("rst_zero_o",  64'(a_zero),    64'd0);
      check("rst_neg_o",   64'(a_neg),     64'd0);
      check("rst_count_o", 64'(a_count),   64'd0);
      check("rst_ready_o", 64'(a_ready_o), 64'd1);
      check("rst16_count", 64'(b_count),   64'd0);
      next_cycle();

      // Back-to-back stream: result of vector c shows up SA cycles later.
      for (int c = 0; c < 8 + int'(SA); c++) begin
         if (c < 8) drive_a(1'b1, vt[c].sel, vt[c].a, vt[c].b);
         else       drive_a(1'b0, 2'd0, '0, '0);
         #1;
         if (c < 8) check("stream_ready", 64'(a_ready_o), 64'd1);
         if (c >= int'(SA)) begin
            check("stream_valid", 64'(a_valid_o), 64'd1);
            check("stream_res",   64'(a_res),     64'(vt[c-SA].res));
            check("stream_zero",  64'(a_zero),    64'(vt[c-SA].zero));
            check("stream_neg",   64'(a_neg),     64'(vt[c-SA].neg));
         end else begin
            check("stream_lat", 64'(a_valid_o), 64'd0);
         end
         next_cycle();
      end

      // Backpressure: five offered, only STAGES fit.
      a_ready_i = 1'b0;
      acc = 0;
      for (int i = 0; i < 5; i++) begin
         drive_a(1'b1, ADD, 32'(10 * i), 32'd1);
         #1;
         if (a_ready_o) acc++;
         next_cycle();
      end
      drive_a(1'b0, 2'd0, '0, '0);
      #1;
      check("bp_accepted", 64'(acc),       64'd3);
      check("bp_count",    64'(a_count),   64'd3);
      check("bp_ready",    64'(a_ready_o), 64'd0);
      check("bp_tail",     64'(a_res),     64'd1);
      next_cycle();
      #1;
      check("bp_stable", 64'(a_res), 64'd1);
      a_ready_i = 1'b1;
      #1;
      check("bp_ready_comb", 64'(a_ready_o), 64'd1);
      for (int j = 0; j < 3; j++) begin
         check("bp_drain_valid", 64'(a_valid_o), 64'd1);
         check("bp_drain_res",   64'(a_res),     64'(10 * j + 1));
         next_cycle();
         #1;
      end
      check("bp_empty_valid", 64'(a_valid_o), 64'd0);
      check("bp_empty_count", 64'(a_count),   64'd0);

      // Bubble collapse: 1,0,0,1 with a stalled sink.
      a_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 0)      drive_a(1'b1, OR,  32'h1234, 32'h0);
         else if (i == 3) drive_a(1'b1, SUB, 32'h50,   32'h8);
         else             drive_a(1'b0, 2'd0, '0, '0);
         next_cycle();
      end
      drive_a(1'b0, 2'd0, '0, '0);
      next_cycle();
      #1;
      check("bub_count", 64'(a_count),   64'd2);
      check("bub_ready", 64'(a_ready_o), 64'd1);
      check("bub_tail",  64'(a_res),     64'h1234);
      a_ready_i = 1'b1;
      #1;
      check("bub_first_valid", 64'(a_valid_o), 64'd1);
      next_cycle();
      #1;
      check("bub_second_valid", 64'(a_valid_o), 64'd1);
      check("bub_second_res",   64'(a_res),     64'h48);
      next_cycle();
      #1;
      check("bub_done", 64'(a_valid_o), 64'd0);

      // Flush with two ops in flight and a new op offered.
      a_ready_i = 1'b0;
      drive_a(1'b1, ADD, 32'hDEAD_0000, 32'h1);
      next_cycle();
      drive_a(1'b1, ADD, 32'hDEAD_0000, 32'h2);
      next_cycle();
      #1;
      check("fl_pre_count", 64'(a_count), 64'd2);
      drive_a(1'b1, ADD, 32'hDEAD_0000, 32'h3);
      a_flush = 1'b1;
      #1;
      check("fl_ready", 64'(a_ready_o), 64'd0);
      next_cycle();
      a_flush = 1'b0;
      drive_a(1'b0, 2'd0, '0, '0);
      #1;
      check("fl_count", 64'(a_count),   64'd0);
      check("fl_valid", 64'(a_valid_o), 64'd0);
      a_ready_i = 1'b1;
      seen = 0;
      for (int i = 0; i < 2 * int'(SA); i++) begin
         #1;
         if (a_valid_o) seen++;
         next_cycle();
      end
      check("fl_no_emerge", 64'(seen), 64'd0);

      // Randomized traffic against a queue model.
      q.delete();
      for (int n = 0; n < 400; n++) begin
         drive_a($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), pick(), pick());
         a_ready_i = ($urandom_range(0, 3) != 0);
         a_flush   = ($urandom_range(0, 49) == 0);
         #1;
         exp_rdy = !a_flush && (q.size() < int'(SA) || a_ready_i);
         check("rnd_ready",  64'(a_ready_o), 64'(exp_rdy));
         check("rnd_count",  64'(a_count),   64'(q.size()));
         check("rnd_orphan", 64'(a_valid_o && q.size() == 0), 64'd0);
         if (a_valid_o && q.size() > 0) begin
            check("rnd_res",  64'(a_res),  64'(q[0].res));
            check("rnd_zero", 64'(a_zero), 64'(q[0].zero));
            check("rnd_neg",  64'(a_neg),  64'(q[0].neg));
            check("rnd_age",  64'(cyc - q[0].t >= int'(SA)), 64'd1);
         end
         xin  = a_valid_i && exp_rdy;
         xout = a_valid_o && a_ready_i;
         if (a_flush) begin
            q.delete();
         end else begin
            if (xout && q.size() > 0) void'(q.pop_front());
            if (xin) begin
               e   = ref_alu(a_sel, a_op1, a_op2);
               e.t = cyc;
               q.push_back(e);
            end
         end
         next_cycle();
      end
      a_flush = 1'b0;
      a_ready_i = 1'b1;
      drive_a(1'b0, 2'd0, '0, '0);
      for (int i = 0; i < int'(SA) + 2; i++) begin
         #1;
         if (a_valid_o && q.size() > 0) begin
            check("rnd_drain_res", 64'(a_res), 64'(q[0].res));
            void'(q.pop_front());
         end
         next_cycle();
      end
      check("rnd_drain_left",  64'(q.size()), 64'd0);
      check("rnd_drain_count", 64'(a_count),  64'd0);

      // Reset mid-stream on the 16-stage instance.
      for (int i = 0; i < 5; i++) begin
         b_valid_i = 1'b1; b_sel = ADD; b_op1 = 32'(i + 1); b_op2 = 32'h100;
         next_cycle();
      end
      b_rst = 1'b1;
      next_cycle();
      b_rst = 1'b0;
      b_valid_i = 1'b0;
      #1;
      check("r16_valid", 64'(b_valid_o), 64'd0);
      check("r16_res",   64'(b_res),     64'd0);
      check("r16_zero",  64'(b_zero),    64'd0);
      check("r16_neg",   64'(b_neg),     64'd0);
      check("r16_count", 64'(b_count),   64'd0);
      b_valid_i = 1'b1; b_sel = ADD; b_op1 = 32'h77; b_op2 = 32'h11;
      next_cycle();
      b_valid_i = 1'b0;
      found = -1;
      for (int k = 1; k <= 40; k++) begin
         #1;
         if (b_valid_o) begin
            found = k;
            break;
         end
         next_cycle();
      end
      check("r16_latency", 64'(found), 64'(SB));
      check("r16_result",  64'(b_res), 64'h88);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
